// File: rtl/crypto_fu_arbiter_if.sv
// Bundle of requester, response and FU-side signals around the crypto FU arbiter.
// Requests: req_valid[i] holds with its operands until req_gnt[i] pulses; a response transfers on a cycle with rsp_valid and rsp_ready both high.
interface crypto_fu_arbiter_if;
   logic [1:0]  req_valid;
   logic [9:0]  req_op;
   logic [63:0] req_rs1;
   logic [63:0] req_rs2;
   logic [7:0]  req_imm;
   logic [1:0]  req_gnt;
   logic        rsp_valid;
   logic        rsp_id;
   logic [31:0] rsp_rd;
   logic        rsp_err;
   logic        rsp_ready;
   logic        fu_valid;
   logic [20:0] fu_op;
   logic [31:0] fu_rs1;
   logic [31:0] fu_rs2;
   logic [3:0]  fu_imm;
   logic        fu_ready;
   logic [31:0] fu_rd;
   logic        busy;
   logic [1:0]  dbg_state;

   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, req_imm, rsp_ready, fu_ready, fu_rd,
      output req_gnt, rsp_valid, rsp_id, rsp_rd, rsp_err,
             fu_valid, fu_op, fu_rs1, fu_rs2, fu_imm, busy, dbg_state
   );

   modport master (
      output req_valid, req_op, req_rs1, req_rs2, req_imm, rsp_ready, fu_ready, fu_rd,
      input  req_gnt, rsp_valid, rsp_id, rsp_rd, rsp_err,
             fu_valid, fu_op, fu_rs1, fu_rs2, fu_imm, busy, dbg_state
   );
endinterface

// File: rtl/crypto_fu_arbiter.sv
// Round-robin two-port arbiter and sequencer for the shared crypto FU, with
// illegal-op rejection and a completion timeout.
module crypto_fu_arbiter #(
   parameter int TIMEOUT = 16
) (
   input logic               g_clk,
   input logic               g_reset,
   crypto_fu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t     state;
   logic       last_gnt;
   logic [7:0] cnt;
   logic       gnt_id;
   logic [4:0] sel_op;

   // On a tie the port not granted last wins; otherwise the lone requester.
   always_comb begin
      gnt_id = (bus.req_valid == 2'b11) ? ~last_gnt : bus.req_valid[1];
      sel_op = gnt_id ? bus.req_op[9:5] : bus.req_op[4:0];
   end

   assign bus.req_gnt   = (state == IDLE && bus.req_valid != 2'b00) ?
                          (gnt_id ? 2'b10 : 2'b01) : 2'b00;
   assign bus.dbg_state = state;

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state         <= IDLE;
         last_gnt      <= 1'b1;
         cnt           <= 8'd0;
         bus.fu_valid  <= 1'b0;
         bus.fu_op     <= 21'd0;
         bus.fu_rs1    <= 32'd0;
         bus.fu_rs2    <= 32'd0;
         bus.fu_imm    <= 4'd0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= 1'b0;
         bus.rsp_rd    <= 32'd0;
         bus.rsp_err   <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid != 2'b00) begin
                  last_gnt   <= gnt_id;
                  bus.rsp_id <= gnt_id;
                  bus.fu_rs1 <= gnt_id ? bus.req_rs1[63:32] : bus.req_rs1[31:0];
                  bus.fu_rs2 <= gnt_id ? bus.req_rs2[63:32] : bus.req_rs2[31:0];
                  bus.fu_imm <= gnt_id ? bus.req_imm[7:4]   : bus.req_imm[3:0];
                  bus.busy   <= 1'b1;
                  if (sel_op <= 5'd20) begin
                     state        <= ISSUE;
                     bus.fu_valid <= 1'b1;
                     bus.fu_op    <= 21'd1 << sel_op;
                     cnt          <= 8'd0;
                  end else begin
                     // Unknown op: answer with an error without touching the FU.
                     state         <= RESP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rd    <= 32'd0;
                  end
               end
            end
            ISSUE: begin
               if (bus.fu_ready || cnt == 8'(TIMEOUT - 1)) begin
                  state         <= RESP;
                  bus.fu_valid  <= 1'b0;
                  bus.fu_op     <= 21'd0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= ~bus.fu_ready;
                  bus.rsp_rd    <= bus.fu_ready ? bus.fu_rd : 32'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state         <= IDLE;
                  bus.rsp_valid <= 1'b0;
                  bus.busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crypto_fu_arbiter.sv
// Self-checking bench for crypto_fu_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level model.
module tb_crypto_fu_arbiter;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   crypto_fu_arbiter_if b();

   crypto_fu_arbiter #(.TIMEOUT(TO)) dut (
      .g_clk   (clk),
      .g_reset (rst),
      .bus     (b)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [33:0] exp_q[$];

   // Model state: outstanding requests per port and the last granted port.
   logic        pend_v[2];
   logic [4:0]  pend_op[2];
   logic [31:0] pend_rs1[2];
   logic [31:0] pend_rs2[2];
   logic [3:0]  pend_imm[2];
   int          last_port;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_reqs();
      b.req_valid = {pend_v[1], pend_v[0]};
      b.req_op    = {pend_op[1], pend_op[0]};
      b.req_rs1   = {pend_rs1[1], pend_rs1[0]};
      b.req_rs2   = {pend_rs2[1], pend_rs2[0]};
      b.req_imm   = {pend_imm[1], pend_imm[0]};
   endtask

   task automatic set_req(input int p, input logic [4:0] op);
      pend_v[p]   = 1'b1;
      pend_op[p]  = op;
      pend_rs1[p] = $urandom;
      pend_rs2[p] = $urandom;
      pend_imm[p] = 4'($urandom_range(0, 15));
   endtask

   task automatic clear_reqs();
      for (int p = 0; p < 2; p++) begin
         pend_v[p] = 1'b0; pend_op[p] = 5'd0;
         pend_rs1[p] = 32'd0; pend_rs2[p] = 32'd0; pend_imm[p] = 4'd0;
      end
   endtask

   // One full transaction from IDLE: d = ISSUE cycle carrying fu_ready (d > TO never),
   // r = RESP cycles waited before rsp_ready, late = probe a stray fu_ready afterwards.
   task automatic txn(input int d, input int r, input logic late);
      int          g;
      logic [4:0]  op;
      logic [31:0] rs1, rs2, rd_val, exp_rd;
      logic [3:0]  imm;
      logic        exp_err;
      logic [33:0] exp;
      @(negedge clk);
      drive_reqs();
      b.fu_ready  = 1'b0;
      b.rsp_ready = 1'b0;
      #1;
      g = (pend_v[0] && pend_v[1]) ? 1 - last_port : (pend_v[0] ? 0 : 1);
      check("gnt", b.req_gnt, (g == 1) ? 2'b10 : 2'b01);
      check("busy_idle", b.busy, 0);
      op = pend_op[g]; rs1 = pend_rs1[g]; rs2 = pend_rs2[g]; imm = pend_imm[g];
      rd_val = $urandom;
      if (op > 5'd20)  begin exp_err = 1'b1; exp_rd = 32'd0;  end
      else if (d <= TO) begin exp_err = 1'b0; exp_rd = rd_val; end
      else              begin exp_err = 1'b1; exp_rd = 32'd0;  end
      exp_q.push_back({exp_err, 1'(g), exp_rd});
      @(posedge clk);
      last_port = g;
      pend_v[g] = 1'b0;
      if (op <= 5'd20) begin
         for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            drive_reqs();
            b.fu_ready  = (k == d);
            b.fu_rd     = (k == d) ? rd_val : $urandom;
            b.rsp_ready = 1'($urandom_range(0, 1));
            #1;
            check("fu_valid", b.fu_valid, 1);
            check("fu_op", b.fu_op, 21'd1 << op);
            check("fu_rs1", b.fu_rs1, rs1);
            check("fu_rs2", b.fu_rs2, rs2);
            check("fu_imm", b.fu_imm, imm);
            check("gnt_issue", b.req_gnt, 0);
            check("rsp_v_issue", b.rsp_valid, 0);
            @(posedge clk);
            if (k == d) break;
         end
      end
      exp = exp_q.pop_front();
      for (int j = 0; j <= r; j++) begin
         @(negedge clk);
         drive_reqs();
         b.fu_ready  = 1'($urandom_range(0, 1));
         b.rsp_ready = (j == r);
         #1;
         check("rsp_valid", b.rsp_valid, 1);
         check("rsp", {b.rsp_err, b.rsp_id, b.rsp_rd}, exp);
         check("fu_valid_resp", b.fu_valid, 0);
         check("fu_op_resp", b.fu_op, 0);
         check("gnt_resp", b.req_gnt, 0);
         check("busy_resp", b.busy, 1);
         @(posedge clk);
      end
      if (late && !pend_v[0] && !pend_v[1]) begin
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            drive_reqs();
            b.fu_ready  = (j == 1);
            b.rsp_ready = 1'b0;
            #1;
            check("late_rsp_v", b.rsp_valid, 0);
            check("late_busy", b.busy, 0);
            check("late_fu_v", b.fu_valid, 0);
            @(posedge clk);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_reqs();
      drive_reqs();
      b.fu_ready = 1'b0; b.rsp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_port = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_reqs();
      drive_reqs();
      b.rsp_ready = 1'b0; b.fu_ready = 1'b0; b.fu_rd = 32'd0;
      last_port = 1;

      // Reset values
      @(negedge clk);
      check("rst_fu_valid", b.fu_valid, 0);
      check("rst_fu_op", b.fu_op, 0);
      check("rst_gnt", b.req_gnt, 0);
      check("rst_rsp_valid", b.rsp_valid, 0);
      check("rst_rsp_err", b.rsp_err, 0);
      check("rst_busy", b.busy, 0);
      check("rst_rsp_rd", b.rsp_rd, 0);
      check("rst_rsp_id", b.rsp_id, 0);
      check("rst_fu_rs", {b.fu_rs1, b.fu_rs2}, 0);
      check("rst_fu_imm", b.fu_imm, 0);
      check("rst_state", b.dbg_state, 0);
      rst = 1'b0;

      // Port 0 op 11, result in the 2nd ISSUE cycle
      set_req(0, 5'd11);
      pend_rs1[0] = 32'h000010ab;
      pend_rs2[0] = 32'h000001cd;
      txn(2, 0, 1'b0);

      // Both ports continuously requesting after reset: port 0 first, then alternating
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (!pend_v[0]) set_req(0, 5'd3);
         if (!pend_v[1]) set_req(1, 5'd7);
         txn(1, 0, 1'b0);
      end

      // Illegal op from port 1
      do_reset();
      set_req(1, 5'd25);
      txn(1, 0, 1'b0);

      // Timeout with a stray fu_ready afterwards
      set_req(0, 5'd2);
      txn(TO + 1, 0, 1'b1);

      // fu_ready in the same cycle the counter reaches TIMEOUT-1
      set_req(1, 5'd19);
      txn(TO, 0, 1'b0);

      // Response held for 5 cycles while the other port waits
      set_req(0, 5'd8);
      set_req(1, 5'd20);
      txn(1, 5, 1'b0);
      txn(3, 0, 1'b0);

      // Reset mid-ISSUE
      set_req(0, 5'd5);
      @(negedge clk);
      drive_reqs();
      b.fu_ready = 1'b0; b.rsp_ready = 1'b0;
      @(posedge clk);
      pend_v[0] = 1'b0;
      @(negedge clk);
      drive_reqs();
      #1;
      check("mid_fu_valid", b.fu_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_fu_valid", b.fu_valid, 0);
      check("mid_rst_busy", b.busy, 0);
      check("mid_rst_fu_op", b.fu_op, 0);
      check("mid_rst_rsp_v", b.rsp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      last_port = 1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         b.fu_ready = 1'($urandom_range(0, 1));
         #1;
         check("post_rst_rsp_v", b.rsp_valid, 0);
         check("post_rst_busy", b.busy, 0);
      end
      set_req(0, 5'd0);
      set_req(1, 5'd1);
      txn(2, 1, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend_v[p] && $urandom_range(0, 1) == 1)
               set_req(p, ($urandom_range(0, 7) == 0) ? 5'($urandom_range(21, 31))
                                                      : 5'($urandom_range(0, 20)));
         end
         if (!pend_v[0] && !pend_v[1]) set_req($urandom_range(0, 1), 5'($urandom_range(0, 20)));
         txn($urandom_range(1, TO + 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
